// File: rtl/serial_parallel.sv
// serial_parallel: receives a 48-bit SD command frame from the CMD line,
// MSB first, and presents {index, argument} plus CRC7/framing/timeout status.
//
// Handshake: iEnable is a level request held by the controller for the whole
// transaction. Once a result is posted (oComplete=1) every result output holds
// until iEnable drops; the block returns to IDLE on that edge with all outputs
// cleared, and it never re-arms while iEnable stays high.
module serial_parallel #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        iSD_clock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iSerial,
    output logic [37:0] oParallel,
    output logic        oComplete,
    output logic        oCrcError,
    output logic        oFrameError,
    output logic        oTimeout,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECEIVE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    // CRC7 generator polynomial x^7 + x^3 + 1 without the implicit x^7 term.
    localparam logic [6:0] CRC_POLY     = 7'h09;
    localparam logic [5:0] LAST_BIT     = 6'd47;
    localparam logic [5:0] LAST_CRC_BIT = 6'd39;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, stateNext;
    logic [5:0]  bitCount, bitCountNext;
    logic [7:0]  timeoutCount, timeoutCountNext;
    // Holds b46..b1; the start bit is implied by entering RECEIVE (always 0).
    logic [45:0] shiftReg, shiftRegNext;
    logic [6:0]  crc, crcNext;
    logic [37:0] parallelNext;
    logic        completeNext, crcErrorNext, frameErrorNext, timeoutNext;

    // One serial CRC7 step: feedback is the incoming bit XOR the register MSB.
    function automatic logic [6:0] crc7Step(input logic [6:0] c, input logic d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
    endfunction

    assign oState = state;

    // Next-state, datapath and result computation; defaults hold everything.
    always_comb begin
        stateNext        = state;
        bitCountNext     = bitCount;
        timeoutCountNext = timeoutCount;
        shiftRegNext     = shiftReg;
        crcNext          = crc;
        parallelNext     = oParallel;
        completeNext     = oComplete;
        crcErrorNext     = oCrcError;
        frameErrorNext   = oFrameError;
        timeoutNext      = oTimeout;

        case (state)
            IDLE: begin
                bitCountNext     = '0;
                timeoutCountNext = '0;
                shiftRegNext     = '0;
                crcNext          = '0;
                parallelNext     = '0;
                completeNext     = 1'b0;
                crcErrorNext     = 1'b0;
                frameErrorNext   = 1'b0;
                timeoutNext      = 1'b0;
                if (iEnable) begin
                    stateNext = WAIT_START;
                end
            end

            WAIT_START: begin
                if (!iEnable) begin
                    stateNext        = IDLE;
                    timeoutCountNext = '0;
                end else if (!iSerial) begin
                    // Start bit b47 seen: it is the first CRC input bit.
                    stateNext        = RECEIVE;
                    bitCountNext     = 6'd1;
                    timeoutCountNext = '0;
                    shiftRegNext     = '0;
                    crcNext          = crc7Step(7'd0, iSerial);
                end else if (timeoutCount == TIMEOUT_LAST) begin
                    stateNext        = DONE;
                    timeoutCountNext = '0;
                    parallelNext     = '0;
                    crcErrorNext     = 1'b0;
                    frameErrorNext   = 1'b0;
                    completeNext     = 1'b1;
                    timeoutNext      = 1'b1;
                end else begin
                    timeoutCountNext = timeoutCount + 8'd1;
                end
            end

            RECEIVE: begin
                if (!iEnable) begin
                    stateNext    = IDLE;
                    bitCountNext = '0;
                    shiftRegNext = '0;
                    crcNext      = '0;
                end else begin
                    shiftRegNext = {shiftReg[44:0], iSerial};
                    // Bits b47..b8 feed the CRC; b7..b1 are the received CRC.
                    if (bitCount <= LAST_CRC_BIT) begin
                        crcNext = crc7Step(crc, iSerial);
                    end
                    if (bitCount == LAST_BIT) begin
                        // iSerial is b0 (end bit); shiftReg holds b46..b1.
                        stateNext      = DONE;
                        bitCountNext   = '0;
                        parallelNext   = shiftReg[44:7];
                        crcErrorNext   = (crc != shiftReg[6:0]);
                        frameErrorNext = shiftReg[45] | ~iSerial;
                        completeNext   = 1'b1;
                        timeoutNext    = 1'b0;
                    end else begin
                        bitCountNext = bitCount + 6'd1;
                    end
                end
            end

            DONE: begin
                if (!iEnable) begin
                    stateNext      = IDLE;
                    parallelNext   = '0;
                    completeNext   = 1'b0;
                    crcErrorNext   = 1'b0;
                    frameErrorNext = 1'b0;
                    timeoutNext    = 1'b0;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset overrides everything.
    always_ff @(posedge iSD_clock) begin
        if (iReset) begin
            state        <= IDLE;
            bitCount     <= '0;
            timeoutCount <= '0;
            shiftReg     <= '0;
            crc          <= '0;
            oParallel    <= '0;
            oComplete    <= 1'b0;
            oCrcError    <= 1'b0;
            oFrameError  <= 1'b0;
            oTimeout     <= 1'b0;
        end else begin
            state        <= stateNext;
            bitCount     <= bitCountNext;
            timeoutCount <= timeoutCountNext;
            shiftReg     <= shiftRegNext;
            crc          <= crcNext;
            oParallel    <= parallelNext;
            oComplete    <= completeNext;
            oCrcError    <= crcErrorNext;
            oFrameError  <= frameErrorNext;
            oTimeout     <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: directed frame table, timeout/abort/reset
// sequences and randomized frames checked against a polynomial-division model.
module tb_serial_parallel;

    logic        clk;
    logic        iReset;
    logic        iEnable;
    logic        iSerial;
    logic [37:0] oParallel;
    logic        oComplete;
    logic        oCrcError;
    logic        oFrameError;
    logic        oTimeout;
    logic [1:0]  oState;

    int vectors;
    int miscompares;

    // Expected result records {parallel, crcError, frameError}.
    logic [39:0] expQ[$];

    typedef struct {
        string       name;
        logic [47:0] frame;
        int          idle;
        logic [37:0] expPar;
        logic        expCrc;
        logic        expFrm;
    } vec_t;

    vec_t table_[5];

    serial_parallel #(.TIMEOUT_CYCLES(64)) dut (
        .iSD_clock  (clk),
        .iReset     (iReset),
        .iEnable    (iEnable),
        .iSerial    (iSerial),
        .oParallel  (oParallel),
        .oComplete  (oComplete),
        .oCrcError  (oCrcError),
        .oFrameError(oFrameError),
        .oTimeout   (oTimeout),
        .oState     (oState)
    );

    // Clock and global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7Model(input logic [39:0] msg);
        logic [46:0] r;
        logic [46:0] g;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) begin
                g = 47'h89;
                r = r ^ (g << (i - 7));
            end
        end
        return r[6:0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic expCmp, input logic [37:0] expPar,
                            input logic expCrc, input logic expFrm, input logic expTo);
        check({name, " complete"}, 64'(oComplete), 64'(expCmp));
        check({name, " parallel"}, 64'(oParallel), 64'(expPar));
        check({name, " crcError"}, 64'(oCrcError), 64'(expCrc));
        check({name, " frameError"}, 64'(oFrameError), 64'(expFrm));
        check({name, " timeout"}, 64'(oTimeout), 64'(expTo));
    endtask

    // Drives idle-high cycles then the 48 frame bits, with the DUT already
    // moving into WAIT_START on the most recent edge; checks the result
    // against the head of expQ, its hold, and the clear after iEnable drops.
    task automatic shiftFrame(input string name, input logic [47:0] frame, input int idle);
        logic [39:0] exp;
        repeat (idle) @(posedge clk);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            iSerial = frame[i];
            if (i == 0) check({name, " early"}, 64'(oComplete), 64'd0);
        end
        @(negedge clk);
        exp = expQ.pop_front();
        checkAll(name, 1'b1, exp[39:2], exp[1], exp[0], 1'b0);
        iSerial = $urandom_range(0, 1);
        repeat (3) @(negedge clk);
        checkAll({name, " hold"}, 1'b1, exp[39:2], exp[1], exp[0], 1'b0);
        iEnable = 1'b0;
        iSerial = 1'b1;
        @(negedge clk);
        checkAll({name, " clear"}, 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runFrame(input string name, input logic [47:0] frame, input int idle);
        @(negedge clk);
        iEnable = 1'b1;
        iSerial = 1'b1;
        @(posedge clk);
        shiftFrame(name, frame, idle);
    endtask

    initial begin
        logic [47:0] frame;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crcField;
        logic        trans;
        logic        endBit;
        logic        saw;

        vectors     = 0;
        miscompares = 0;
        iReset      = 1'b1;
        iEnable     = 1'b0;
        iSerial     = 1'b1;

        table_[0] = '{"zero frame",  48'h000000000001, 3, 38'h0000000000, 1'b0, 1'b0};
        table_[1] = '{"cmd8",        48'h48000001AA87, 2, 38'h08000001AA, 1'b0, 1'b1};
        table_[2] = '{"cmd8 flip",   48'h48000001AB87, 0, 38'h08000001AB, 1'b1, 1'b1};
        table_[3] = '{"no end bit",  48'h000000000000, 5, 38'h0000000000, 1'b0, 1'b1};
        table_[4] = '{"bad crc",     48'h000000000003, 1, 38'h0000000000, 1'b1, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        checkAll("reset", 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);
        iReset = 1'b0;
        @(negedge clk);
        checkAll("idle", 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            expQ.push_back({table_[v].expPar, table_[v].expCrc, table_[v].expFrm});
            runFrame(table_[v].name, table_[v].frame, table_[v].idle);
        end

        // Timeout: 64 high samples in WAIT_START, then hold without re-arming.
        @(negedge clk);
        iEnable = 1'b1;
        iSerial = 1'b1;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk);
        checkAll("timeout early", 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkAll("timeout", 1'b1, 38'd0, 1'b0, 1'b0, 1'b1);
        repeat (70) @(negedge clk);
        checkAll("timeout hold", 1'b1, 38'd0, 1'b0, 1'b0, 1'b1);
        iEnable = 1'b0;
        @(negedge clk);
        checkAll("timeout clear", 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);

        // Abort by dropping iEnable at bit 20 of RECEIVE.
        frame = 48'h48000001AA87;
        @(negedge clk);
        iEnable = 1'b1;
        @(posedge clk);
        for (int i = 47; i >= 28; i--) begin
            @(negedge clk);
            iSerial = frame[i];
        end
        @(negedge clk);
        iEnable = 1'b0;
        iSerial = 1'b1;
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (oComplete) saw = 1'b1;
        end
        check("abort no complete", 64'(saw), 64'd0);
        expQ.push_back({38'h08000001AA, 1'b0, 1'b1});
        runFrame("after abort", frame, 2);

        // Reset pulse mid-RECEIVE with iEnable held high.
        @(negedge clk);
        iEnable = 1'b1;
        @(posedge clk);
        for (int i = 47; i >= 37; i--) begin
            @(negedge clk);
            iSerial = frame[i];
        end
        @(negedge clk);
        iReset  = 1'b1;
        iSerial = 1'b1;
        @(negedge clk);
        iReset = 1'b0;
        checkAll("reset abort", 1'b0, 38'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        saw = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (oComplete) saw = 1'b1;
        end
        check("reset no complete", 64'(saw), 64'd0);
        expQ.push_back({38'h08000001AA, 1'b0, 1'b1});
        shiftFrame("after reset", frame, 0);

        // Randomized frames against the reference model.
        for (int n = 0; n < 30; n++) begin
            idx    = 6'($urandom_range(0, 63));
            arg    = $urandom;
            trans  = ($urandom_range(0, 3) == 0);
            endBit = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                crcField = crc7Model({1'b0, trans, idx, arg});
            else
                crcField = 7'($urandom_range(0, 127));
            frame = {1'b0, trans, idx, arg, crcField, endBit};
            expQ.push_back({idx, arg,
                            (crcField != crc7Model({1'b0, trans, idx, arg})),
                            (trans | ~endBit)});
            runFrame($sformatf("random %0d", n), frame, $urandom_range(0, 10));
        end

        check("queue drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
SERIAL_PARALLEL -- requirements
Module: serial_parallel

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, number of clocks to wait for a start bit before aborting (range 1..255).
REQ-002 iSD_clock  input  1  clock; all logic SHALL be on its rising edge.
REQ-003 iReset  input  1  reset; synchronous and active-high.
REQ-004 iEnable  input  1  receive request; level-held by the controller for the whole transaction.
REQ-005 iSerial  input  1  SD CMD line; idles high; MSB first.
REQ-006 oParallel  output  38  received {index[5:0], argument[31:0]}.
REQ-007 oComplete  output  1  frame received; result outputs valid.
REQ-008 oCrcError  output  1  CRC7 mismatch on the received frame.
REQ-009 oFrameError  output  1  transmission bit not 0 or end bit not 1.
REQ-010 oTimeout  output  1  no start bit within TIMEOUT_CYCLES.

Function
REQ-011 Frame: 48 bits, b47..b0 = start(0), transmission, index[5:0], argument[31:0], CRC7[6:0], end.
REQ-012 FSM states: IDLE, WAIT_START, RECEIVE, DONE.
REQ-013 IDLE: iEnable=1 -> WAIT_START next cycle; timeout counter cleared.
REQ-014 WAIT_START: iSerial=0 sampled -> b47 captured, bit counter=1, -> RECEIVE.
REQ-015 WAIT_START: each cycle with iSerial=1 increments timeout counter; on the TIMEOUT_CYCLES-th such cycle -> DONE with oTimeout=1, oComplete=1.
REQ-016 RECEIVE: one bit shifted in per clock; after the 48th bit is sampled (cycle N+47, where N is the start-bit cycle) -> DONE.
REQ-017 Latency: oComplete, oParallel, oCrcError, oFrameError SHALL be valid at cycle N+48, all updated on the same edge.
REQ-018 CRC7: polynomial x^7+x^3+1, initial value 0, computed serially over b47..b8; oCrcError=1 iff result != b7..b1.
REQ-019 oFrameError=1 iff b46!=0 or b0!=1; it is independent of oCrcError (both may be set).
REQ-020 On timeout, oParallel, oCrcError, and oFrameError SHALL be 0.
REQ-021 DONE: all result outputs held stable while iEnable=1; iEnable=0 -> IDLE next cycle, and all outputs clear to 0 on that edge.
REQ-022 iEnable=0 in WAIT_START or RECEIVE -> IDLE next cycle; partial data is discarded and oComplete is never asserted.
REQ-023 Outside DONE, oComplete, oCrcError, oFrameError, and oTimeout SHALL be 0, and oParallel SHALL be 0.
REQ-024 A new transaction SHALL require iEnable low for at least 1 cycle after DONE; the block never re-arms while iEnable stays high.
REQ-025 Bit counter 6 bits; timeout counter 8 bits; neither wraps (both saturate or are cleared on state exit).

Reset
REQ-026 iReset=1 at a rising edge -> IDLE, all outputs 0, shift register, CRC, and counters 0; it overrides all other inputs in any state.
REQ-027 Reset asserted mid-RECEIVE SHALL abort with no oComplete; after release, the block waits in IDLE for iEnable (a new rising level is not needed if iEnable is still high).

Verification
REQ-028 iEnable=1, frame 48'h000000000001 after 3 idle-high cycles -> oComplete=1 at N+48, oParallel=0, oCrcError=0, oFrameError=0, oTimeout=0.
REQ-029 Frame 48'h48000001AA87 -> oParallel=38'h08000001AA, oCrcError=0, oFrameError=1.
REQ-030 Frame 48'h48000001AA87 with argument bit 0 flipped (48'h48000001AB87) -> oCrcError=1, oFrameError=1, oParallel=38'h08000001AB.
REQ-031 iEnable=1, iSerial held 1 -> oTimeout=1 and oComplete=1 exactly 64 cycles after entering WAIT_START; dropping iEnable clears both the next cycle.
REQ-032 iEnable dropped at bit 20 of RECEIVE -> IDLE next cycle, oComplete stays 0; a re-enabled valid frame then decodes correctly.
REQ-033 iReset pulsed 1 cycle during RECEIVE with iEnable held high -> all outputs 0, no oComplete for the aborted frame; the next full frame yields oComplete at N+48.
